dlx_mem_arbiter: RTL and testbench

Shares one unified single-port memory between the DLX instruction-fetch port and the data-access port.
- Sits between the processor's instr_*/data_* buses and the external memory.
- Serialises accesses, returning completion strobes the pipeline uses as stall release.
- Data accesses win by default; a bounded starvation counter guarantees fetch progress.
- A watchdog aborts accesses that never complete.

---
 rtl/dlx_mem_arbiter_pkg.sv | 17 +
 rtl/mem_arb_timeout_counter.sv | 29 ++
 rtl/dlx_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_dlx_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_mem_arbiter_pkg.sv
// Shared constants and state type for the DLX unified-memory arbiter.
package dlx_mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_INST = 2'd1;
    localparam logic [1:0] ARB_DATA = 2'd2;

    localparam int unsigned DEF_MAX_DATA_BURST = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        StIdle = ARB_IDLE,
        StInst = ARB_INST,
        StData = ARB_DATA
    } arb_state_e;

endpackage

// File: rtl/mem_arb_timeout_counter.sv
// Counts memory wait cycles during an access; flags expiry at TIMEOUT_CYCLES.
module mem_arb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = dlx_mem_arbiter_pkg::DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] wait_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (clear) begin
            wait_cnt_q <= '0;
        end else if (count_en && (wait_cnt_q != Limit)) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign expired = (wait_cnt_q == Limit);

endmodule

// File: rtl/dlx_mem_arbiter.sv
// Arbitrates DLX fetch and data ports onto one single-port memory; data wins
// by default, a starvation counter forces a fetch after MAX_DATA_BURST data grants.
module dlx_mem_arbiter
    import dlx_mem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned INST_ADDR_WIDTH = 20,
    parameter int unsigned DATA_ADDR_WIDTH = 32,
    parameter int unsigned MAX_DATA_BURST  = DEF_MAX_DATA_BURST,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_rd_en,
    input  logic [INST_ADDR_WIDTH-1:0] instr_addr,
    output logic                       instr_done,
    output logic [DATA_WIDTH-1:0]      instruction,
    input  logic                       data_rd_en,
    input  logic                       data_wr_en,
    input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0]      data_write,
    output logic                       data_done,
    output logic [DATA_WIDTH-1:0]      data_read,
    output logic                       bus_err,
    output logic                       mem_req,
    output logic                       mem_wr,
    output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    input  logic                       mem_ready
);

    localparam int unsigned StW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [StW-1:0] StarveMax = StW'(MAX_DATA_BURST);

    arb_state_e                 state_q;
    logic                       mem_req_q;
    logic                       mem_wr_q;
    logic [DATA_ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0]      mem_wdata_q;
    logic [StW-1:0]             starve_cnt_q;
    logic                       conflict_q;

    logic data_pend;
    logic grant_inst;
    logic grant_data;
    logic in_inst;
    logic in_data;
    logic expired;
    logic acc_end;
    logic rd_ok;

    always_comb begin
        data_pend  = data_rd_en | data_wr_en;
        grant_inst = instr_rd_en & (~data_pend | (starve_cnt_q == StarveMax));
        grant_data = data_pend & ~grant_inst;
        in_inst    = (state_q == StInst);
        in_data    = (state_q == StData);
        acc_end    = (in_inst | in_data) & (mem_ready | expired);
        // Timeout takes precedence so an aborted access never returns stale data
        rd_ok      = mem_ready & ~expired;
    end

    mem_arb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == StIdle),
        .count_en((in_inst | in_data) & ~mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            starve_cnt_q <= '0;
            conflict_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_inst) begin
                        state_q      <= StInst;
                        mem_req_q    <= 1'b1;
                        mem_wr_q     <= 1'b0;
                        mem_addr_q   <= DATA_ADDR_WIDTH'(instr_addr);
                        starve_cnt_q <= '0;
                        conflict_q   <= 1'b0;
                    end else if (grant_data) begin
                        state_q     <= StData;
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= data_wr_en;
                        mem_addr_q  <= data_addr;
                        mem_wdata_q <= data_write;
                        conflict_q  <= data_rd_en & data_wr_en;
                        if (!instr_rd_en) begin
                            starve_cnt_q <= '0;
                        end else if (starve_cnt_q != StarveMax) begin
                            starve_cnt_q <= starve_cnt_q + 1'b1;
                        end
                    end
                end
                StInst, StData: begin
                    // Always pass through idle so a held request is re-arbitrated fresh
                    if (acc_end) begin
                        state_q   <= StIdle;
                        mem_req_q <= 1'b0;
                        mem_wr_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    mem_req_q <= 1'b0;
                    mem_wr_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        instr_done  = in_inst & (mem_ready | expired);
        data_done   = in_data & (mem_ready | expired);
        instruction = (in_inst & rd_ok) ? mem_rdata : '0;
        data_read   = (in_data & rd_ok) ? mem_rdata : '0;
        bus_err     = acc_end & (expired | (in_data & conflict_q));
    end

    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Scoreboard bench for dlx_mem_arbiter: driver queues expected completions,
// a negedge monitor pops and compares on every done strobe.
module tb_dlx_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        instr_rd_en;
    logic [19:0] instr_addr;
    logic        instr_done;
    logic [31:0] instruction;
    logic        data_rd_en;
    logic        data_wr_en;
    logic [31:0] data_addr;
    logic [31:0] data_write;
    logic        data_done;
    logic [31:0] data_read;
    logic        bus_err;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    dlx_mem_arbiter #(
        .DATA_WIDTH     (32),
        .INST_ADDR_WIDTH(20),
        .DATA_ADDR_WIDTH(32),
        .MAX_DATA_BURST (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_rd_en(instr_rd_en),
        .instr_addr (instr_addr),
        .instr_done (instr_done),
        .instruction(instruction),
        .data_rd_en (data_rd_en),
        .data_wr_en (data_wr_en),
        .data_addr  (data_addr),
        .data_write (data_write),
        .data_done  (data_done),
        .data_read  (data_read),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        bit          err;
        logic [31:0] addr;
        bit          wr;
        bit          chk_wdata;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic push(input bit is_data, input logic [31:0] rdata, input bit err,
                        input logic [31:0] addr, input bit wr, input bit chk_wdata,
                        input logic [31:0] wdata);
        exp_t e;
        e.is_data   = is_data;
        e.rdata     = rdata;
        e.err       = err;
        e.addr      = addr;
        e.wr        = wr;
        e.chk_wdata = chk_wdata;
        e.wdata     = wdata;
        sb.push_back(e);
    endtask

    // Monitor: one scoreboard entry per done strobe
    always @(negedge clk) begin
        if (!rst && (instr_done || data_done)) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {62'b0, instr_done, data_done}, 64'd0);
            end else begin
                me = sb.pop_front();
                check("done_kind", {62'b0, instr_done, data_done},
                      {62'b0, !me.is_data, me.is_data});
                check("rdata", me.is_data ? data_read : instruction, me.rdata);
                check("other_rdata", me.is_data ? instruction : data_read, 64'd0);
                check("bus_err", bus_err, me.err);
                check("mem_req_at_done", mem_req, 64'd1);
                check("mem_addr", mem_addr, me.addr);
                check("mem_wr", mem_wr, me.wr);
                if (me.chk_wdata) check("mem_wdata", mem_wdata, me.wdata);
            end
        end else if (!rst && bus_err) begin
            check("stray_bus_err", bus_err, 64'd0);
        end
    end

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = instr_done | data_done;
        end
        check(name, {63'b0, seen}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst         = 1'b1;
        instr_rd_en = 1'b0;
        instr_addr  = '0;
        data_rd_en  = 1'b0;
        data_wr_en  = 1'b0;
        data_addr   = '0;
        data_write  = '0;
        mem_rdata   = '0;
        mem_ready   = 1'b0;

        @(negedge clk);
        check("reset_mem", {mem_req, mem_wr, mem_addr, mem_wdata[29:0]}, 64'd0);
        check("reset_strobes", {instr_done, data_done, bus_err}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single zero-wait fetch
        instr_rd_en = 1'b1;
        instr_addr  = 20'h40000;
        mem_ready   = 1'b1;
        mem_rdata   = 32'h2001_0005;
        push(1'b0, 32'h2001_0005, 1'b0, 32'h0004_0000, 1'b0, 1'b0, 32'h0);
        wait_done("fetch_done_seen");
        instr_rd_en = 1'b0;
        @(negedge clk);
        check("fetch_req_drop", mem_req, 64'd0);
        @(posedge clk);
        #1;

        // Write with three wait states
        data_wr_en = 1'b1;
        data_addr  = 32'h100;
        data_write = 32'hDEAD_BEEF;
        mem_ready  = 1'b0;
        push(1'b1, 32'h2001_0005, 1'b0, 32'h100, 1'b1, 1'b1, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) mem_ready = 1'b1;
            @(negedge clk);
            check("write_stable", {mem_req, mem_wr, mem_wdata}, {2'b11, 32'hDEAD_BEEF});
            check("write_done_timing", {63'b0, data_done}, {63'b0, k == 4});
            @(posedge clk);
            #1;
        end
        data_wr_en = 1'b0;
        @(negedge clk);
        check("write_req_drop", mem_req, 64'd0);
        @(posedge clk);
        #1;

        // Contention: expected grant order D,D,D,D,I,D,D,D,D,I
        instr_rd_en = 1'b1;
        instr_addr  = 20'h00123;
        data_rd_en  = 1'b1;
        data_addr   = 32'h200;
        mem_rdata   = 32'h1111_2222;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) push(1'b1, 32'h1111_2222, 1'b0, 32'h200, 1'b0, 1'b0, 0);
            push(1'b0, 32'h1111_2222, 1'b0, 32'h123, 1'b0, 1'b0, 0);
        end
        for (int n = 0; n < 10; n++) wait_done("contention_done_seen");
        instr_rd_en = 1'b0;
        data_rd_en  = 1'b0;
        @(posedge clk);
        #1;

        // Timeout: eight wait cycles, abort strobe in the ninth
        data_rd_en = 1'b1;
        data_addr  = 32'h300;
        mem_ready  = 1'b0;
        mem_rdata  = 32'hFFFF_FFFF;
        push(1'b1, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("timeout_timing", {62'b0, data_done, bus_err}, {62'b0, k == 9, k == 9});
            @(posedge clk);
            #1;
        end
        data_rd_en = 1'b0;
        @(negedge clk);
        check("timeout_req_drop", mem_req, 64'd0);
        @(posedge clk);
        #1;

        // Read/write conflict performed as a write with bus_err
        data_rd_en = 1'b1;
        data_wr_en = 1'b1;
        data_addr  = 32'h400;
        data_write = 32'h1234_5678;
        mem_ready  = 1'b1;
        mem_rdata  = 32'h0;
        push(1'b1, 32'h0, 1'b1, 32'h400, 1'b1, 1'b1, 32'h1234_5678);
        wait_done("conflict_done_seen");
        data_rd_en = 1'b0;
        data_wr_en = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid data access, then a pending fetch is granted first
        data_rd_en = 1'b1;
        data_addr  = 32'h500;
        mem_ready  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_reset_req", mem_req, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid_access", {62'b0, mem_req, data_done}, 64'd0);
        data_rd_en  = 1'b0;
        instr_rd_en = 1'b1;
        instr_addr  = 20'h00777;
        mem_ready   = 1'b1;
        mem_rdata   = 32'h0BAD_F00D;
        push(1'b0, 32'h0BAD_F00D, 1'b0, 32'h777, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_done("post_reset_fetch_seen");
        instr_rd_en = 1'b0;
        @(posedge clk);
        #1;

        check("scoreboard_drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
